// File: rtl/acc_core_if.sv
// Shared memory port between acc_core and its program/data RAM.
// The core drives address, write data and write enable; the RAM returns read data.
interface acc_core_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
);
    logic [DATA_W-1:0] datain;
    logic [ADDR_W-1:0] addrout;
    logic [DATA_W-1:0] dataout;
    logic              we;

    modport master (
        input  datain,
        output addrout,
        output dataout,
        output we
    );

    modport slave (
        output datain,
        input  addrout,
        input  dataout,
        input  we
    );
endinterface

// File: rtl/acc_core.sv
// Multi-cycle accumulator CPU on a single shared memory port.
// Fetch/decode/memory phases are sequenced by a small FSM; memory read latency is MEM_LAT.
module acc_core #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned START_ADDR = 9216,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic       clock,
    input  logic       reset,
    acc_core_if.master bus,
    output logic       halted,
    output logic       retire
);
    localparam int unsigned IMM_W = DATA_W - 4;
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

    localparam logic [2:0] StFetch = 3'd0;
    localparam logic [2:0] StFwait = 3'd1;
    localparam logic [2:0] StExec  = 3'd2;
    localparam logic [2:0] StMem   = 3'd3;
    localparam logic [2:0] StMwait = 3'd4;
    localparam logic [2:0] StHalt  = 3'd5;

    localparam logic [3:0] OpLoad  = 4'd0;
    localparam logic [3:0] OpStore = 4'd1;
    localparam logic [3:0] OpAddi  = 4'd2;
    localparam logic [3:0] OpAdddp = 4'd3;
    localparam logic [3:0] OpJmp   = 4'd4;
    localparam logic [3:0] OpJz    = 4'd5;
    localparam logic [3:0] OpHalt  = 4'd6;
    localparam logic [3:0] OpAddm  = 4'd7;
    localparam logic [3:0] OpRst   = 4'd15;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] dp_q, dp_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              we_q, we_d;

    logic [3:0]        opcode;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_rel;
    logic              wait_last;

    assign opcode    = ir_q[DATA_W-1:DATA_W-4];
    assign imm       = ir_q[IMM_W-1:0];
    assign imm_data  = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_rel    = pc_q + imm_addr;
    assign wait_last = (wcnt_q == WAIT_LAST);

    // Address offsets are sign-extended or truncated depending on relative widths.
    if (ADDR_W > IMM_W) begin : g_imm_ext
        assign imm_addr = {{(ADDR_W - IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_imm_trunc
        assign imm_addr = imm[ADDR_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dp_d    = dp_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                wcnt_d  = 3'd0;
                state_d = StFwait;
            end
            StFwait: begin
                if (wait_last) begin
                    ir_d    = bus.datain;
                    state_d = StExec;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            StExec: begin
                // Default: single-cycle instruction, fall through to the next word.
                pc_d    = pc_inc;
                addr_d  = pc_inc;
                state_d = StFetch;
                retire  = 1'b1;
                case (opcode)
                    OpLoad, OpAddm: begin
                        addr_d  = dp_q;
                        state_d = StMem;
                        retire  = 1'b0;
                    end
                    OpStore: begin
                        addr_d  = dp_q;
                        dout_d  = acc_q;
                        we_d    = 1'b1;
                        state_d = StMem;
                        retire  = 1'b0;
                    end
                    OpAddi:  acc_d = acc_q + imm_data;
                    OpAdddp: dp_d = dp_q + imm_addr;
                    OpJmp: begin
                        pc_d   = pc_rel;
                        addr_d = pc_rel;
                    end
                    OpJz: begin
                        if (acc_q == '0) begin
                            pc_d   = pc_rel;
                            addr_d = pc_rel;
                        end
                    end
                    OpHalt: begin
                        addr_d  = addr_q;
                        state_d = StHalt;
                    end
                    OpRst: begin
                        pc_d   = START_PC;
                        addr_d = START_PC;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                wcnt_d = 3'd0;
                if (opcode == OpStore) begin
                    retire  = 1'b1;
                    addr_d  = pc_q;
                    state_d = StFetch;
                end else begin
                    state_d = StMwait;
                end
            end
            StMwait: begin
                if (wait_last) begin
                    retire  = 1'b1;
                    addr_d  = pc_q;
                    state_d = StFetch;
                    acc_d   = (opcode == OpLoad) ? bus.datain : acc_q + bus.datain;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= START_PC;
            dp_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            wcnt_q  <= 3'd0;
            addr_q  <= START_PC;
            dout_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
        end
    end

    assign bus.addrout = addr_q;
    assign bus.dataout = dout_q;
    assign bus.we      = we_q;
    assign halted      = (state_q == StHalt);
endmodule

// File: tb/tb_acc_core.sv
// Directed bench for acc_core: one core with MEM_LAT=1 and one with MEM_LAT=3,
// each on its own behavioural RAM.
module tb_acc_core;
    logic clock = 1'b0;
    logic reset1 = 1'b1;
    logic reset3 = 1'b1;
    logic halted1, retire1, halted3, retire3;

    logic        ld1 = 1'b0;
    logic        ld3 = 1'b0;
    logic [14:0] ld_a = '0;
    logic [15:0] ld_d = '0;

    logic [15:0] mem1 [0:32767];
    logic [15:0] mem3 [0:32767];
    logic [15:0] rd1;
    logic [15:0] p3 [0:2];

    int cyc = 0;
    int we_cnt1 = 0;
    logic [14:0] last_wa = '0;
    logic [15:0] last_wd = '0;
    logic ret1_prev = 1'b0;
    int rq1[$];
    int rq3[$];
    int fq1[$];

    int n_assert = 0;
    int n_fail = 0;
    int rb, wb, fb;

    acc_core_if #(.DATA_W(16), .ADDR_W(15)) bus1 ();
    acc_core_if #(.DATA_W(16), .ADDR_W(15)) bus3 ();

    acc_core #(.DATA_W(16), .ADDR_W(15), .START_ADDR(9216), .MEM_LAT(1)) dut1 (
        .clock (clock),
        .reset (reset1),
        .bus   (bus1),
        .halted(halted1),
        .retire(retire1)
    );

    acc_core #(.DATA_W(16), .ADDR_W(15), .START_ADDR(9216), .MEM_LAT(3)) dut3 (
        .clock (clock),
        .reset (reset3),
        .bus   (bus3),
        .halted(halted3),
        .retire(retire3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ld1) mem1[ld_a] <= ld_d;
        else if (bus1.we) mem1[bus1.addrout] <= bus1.dataout;
        rd1 <= mem1[bus1.addrout];
        if (ld3) mem3[ld_a] <= ld_d;
        else if (bus3.we) mem3[bus3.addrout] <= bus3.dataout;
        p3[0] <= mem3[bus3.addrout];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.datain = rd1;
    assign bus3.datain = p3[2];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (retire1) rq1.push_back(cyc);
        if (retire3) rq3.push_back(cyc);
        if (ret1_prev) fq1.push_back(int'(bus1.addrout));
        ret1_prev <= retire1;
        if (bus1.we) begin
            we_cnt1 <= we_cnt1 + 1;
            last_wa <= bus1.addrout;
            last_wd <= bus1.dataout;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input bit to3, input int a, input int d);
        ld_a = 15'(a);
        ld_d = 16'(d);
        if (to3) ld3 = 1'b1;
        else ld1 = 1'b1;
        tick(1);
        ld1 = 1'b0;
        ld3 = 1'b0;
    endtask

    function automatic int rq1_at(input int i);
        return (i < rq1.size()) ? rq1[i] : -1000;
    endfunction

    function automatic int rq3_at(input int i);
        return (i < rq3.size()) ? rq3[i] : -1000;
    endfunction

    function automatic int fq1_at(input int i);
        return (i < fq1.size()) ? fq1[i] : -1;
    endfunction

    task automatic release1();
        rb = rq1.size();
        wb = we_cnt1;
        fb = fq1.size();
        reset1 = 1'b0;
    endtask

    initial begin
        tick(2);

        // Reset state, ADDI/STORE/HALT program
        poke(0, 9216, 'h2005);
        poke(0, 9217, 'h2FFF);
        poke(0, 9218, 'h1000);
        poke(0, 9219, 'h6000);
        release1();
        check("rst_addrout", 32'(bus1.addrout), 9216);
        check("rst_we", 32'(bus1.we), 0);
        check("rst_halted", 32'(halted1), 0);
        check("rst_retire", 32'(retire1), 0);
        tick(1);
        check("retire_c1", 32'(retire1), 0);
        tick(1);
        check("retire_c2", 32'(retire1), 1);
        tick(18);
        check("p1_retires", 32'(rq1.size() - rb), 4);
        check("p1_we_pulses", 32'(we_cnt1 - wb), 1);
        check("p1_we_addr", 32'(last_wa), 0);
        check("p1_we_data", 32'(last_wd), 4);
        check("p1_mem0", 32'(mem1[0]), 4);
        check("p1_store_cycles", 32'(rq1_at(rb + 2) - rq1_at(rb + 1)), 4);
        check("p1_halted", 32'(halted1), 1);
        check("p1_halt_addr", 32'(bus1.addrout), 9219);
        tick(5);
        check("p1_halt_stays", 32'(halted1), 1);
        check("p1_halt_noretire", 32'(rq1.size() - rb), 4);

        // LOAD / ADDM / STORE with MEM_LAT=1
        reset1 = 1'b1;
        tick(1);
        check("p2_rst_halted", 32'(halted1), 0);
        poke(0, 3, 'h1234);
        poke(0, 9216, 'h3003);
        poke(0, 9217, 'h0000);
        poke(0, 9218, 'h7000);
        poke(0, 9219, 'h1000);
        poke(0, 9220, 'h6000);
        release1();
        tick(26);
        check("p2_mem3", 32'(mem1[3]), 'h2468);
        check("p2_we_addr", 32'(last_wa), 3);
        check("p2_load_cycles", 32'(rq1_at(rb + 1) - rq1_at(rb)), 5);
        check("p2_addm_cycles", 32'(rq1_at(rb + 2) - rq1_at(rb + 1)), 5);
        check("p2_halted", 32'(halted1), 1);

        // Same program with MEM_LAT=3
        poke(1, 3, 'h1234);
        poke(1, 9216, 'h3003);
        poke(1, 9217, 'h0000);
        poke(1, 9218, 'h7000);
        poke(1, 9219, 'h1000);
        poke(1, 9220, 'h6000);
        reset3 = 1'b0;
        check("l3_rst_addrout", 32'(bus3.addrout), 9216);
        tick(45);
        check("l3_mem3", 32'(mem3[3]), 'h2468);
        check("l3_load_cycles", 32'(rq3_at(1) - rq3_at(0)), 9);
        check("l3_addm_cycles", 32'(rq3_at(2) - rq3_at(1)), 9);
        check("l3_store_cycles", 32'(rq3_at(3) - rq3_at(2)), 6);
        check("l3_halted", 32'(halted3), 1);

        // JZ taken / not taken, JMP backwards
        reset1 = 1'b1;
        tick(1);
        poke(0, 9216, 'h5002);
        poke(0, 9217, 'h2063);
        poke(0, 9218, 'h2001);
        poke(0, 9219, 'h5002);
        poke(0, 9220, 'h4FFF);
        release1();
        tick(18);
        check("jz_taken", 32'(fq1_at(fb)), 9218);
        check("addi_next", 32'(fq1_at(fb + 1)), 9219);
        check("jz_fall", 32'(fq1_at(fb + 2)), 9220);
        check("jmp_back", 32'(fq1_at(fb + 3)), 9219);
        check("jz_fall2", 32'(fq1_at(fb + 4)), 9220);

        // Legacy jump word 0xFF43 decodes as RST
        reset1 = 1'b1;
        tick(1);
        poke(0, 9216, 'h4054);
        poke(0, 9300, 'hFF43);
        release1();
        tick(12);
        check("jmp_fwd", 32'(fq1_at(fb)), 9300);
        check("rst_op", 32'(fq1_at(fb + 1)), 9216);
        check("rst_op_again", 32'(fq1_at(fb + 2)), 9300);

        // Backward jump chain wrapping to 0x7FFF, then NOP wraps PC to 0
        reset1 = 1'b1;
        tick(1);
        poke(0, 9216, 'h4800);
        poke(0, 7168, 'h4800);
        poke(0, 5120, 'h4800);
        poke(0, 3072, 'h4800);
        poke(0, 1024, 'h4800);
        poke(0, 31744, 'h43FF);
        poke(0, 32767, 'h8000);
        poke(0, 0, 'h6000);
        release1();
        tick(30);
        check("jmp_wrap_neg", 32'(fq1_at(fb + 4)), 31744);
        check("jmp_to_top", 32'(fq1_at(fb + 5)), 32767);
        check("pc_wrap", 32'(fq1_at(fb + 6)), 0);
        check("wrap_halted", 32'(halted1), 1);

        // Reset during STORE and during FWAIT
        reset1 = 1'b1;
        tick(1);
        poke(0, 9216, 'h2007);
        poke(0, 9217, 'h1000);
        poke(0, 9218, 'h6000);
        release1();
        tick(6);
        check("st_we", 32'(bus1.we), 1);
        check("st_addr", 32'(bus1.addrout), 0);
        check("st_data", 32'(bus1.dataout), 7);
        reset1 = 1'b1;
        tick(1);
        check("st_rst_we", 32'(bus1.we), 0);
        check("st_rst_addr", 32'(bus1.addrout), 9216);
        reset1 = 1'b0;
        tick(1);
        reset1 = 1'b1;
        tick(1);
        check("fw_rst_addr", 32'(bus1.addrout), 9216);
        check("fw_rst_we", 32'(bus1.we), 0);
        check("fw_rst_retire", 32'(retire1), 0);
        release1();
        tick(20);
        check("rr_we_pulses", 32'(we_cnt1 - wb), 1);
        check("rr_acc_cleared", 32'(last_wd), 7);
        check("rr_halted", 32'(halted1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
